prio_encoder_rr: RTL

//  Parametrised N:log2(N) priority encoder with a registered, handshaked output.
//  Two modes: fixed priority, where the highest index wins, and round-robin.
//  It picks one of N request lines and presents the index plus a one-hot grant to
//  a downstream consumer. The result is held until the consumer accepts it.

---
 rtl/prio_enc_pkg.sv | 13 +
 rtl/prio_find_first.sv | 44 ++++
 rtl/prio_encoder_rr.sv | 105 ++++++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the priority encoder / round-robin arbiter front-end.
// Holds the mode selectors and the output FSM state type.
package prio_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } prio_state_t;

endpackage

// File: rtl/prio_find_first.sv
// Combinational search for the first set request, starting at ptr and walking
// downwards with wrap-around.
module prio_find_first #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Maps ptr + 1 + offset back into 0..N-1; the sum never exceeds 2N-1.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W+1:0] s);
        if (s >= (IDX_W+2)'(N))
            return IDX_W'(s - (IDX_W+2)'(N));
        else
            return IDX_W'(s);
    endfunction

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] rot_sel;

    // rot[N-1] is the request at ptr, rot[N-2] at ptr-1, and so on, so the
    // highest set bit of rot is the first request in search order.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = req[wrap_idx({2'b00, ptr} + (IDX_W+2)'(gi + 1))];
        end
    endgenerate

    always_comb begin
        rot_sel = '0;
        for (int j = 0; j < N; j++) begin
            if (rot[j])
                rot_sel = IDX_W'(j);
        end
    end

    assign found = |req;
    assign idx   = wrap_idx({2'b00, ptr} + {2'b00, rot_sel} + (IDX_W+2)'(1));

endmodule

// File: rtl/prio_encoder_rr.sv
// N:log2(N) priority encoder with a registered valid/ready output; fixed
// (highest index wins) or round-robin priority.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int N     = 8,
    parameter int MODE  = MODE_FIXED,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot
);

    localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(N - 1);

    prio_state_t      state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [N-1:0]     onehot_reg;

    logic             accept;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] search_ptr;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_onehot;

    assign accept = (state_reg == HOLD) && out_ready;

    // The accepted source drops to lowest priority; fixed mode never moves.
    always_comb begin
        ptr_next = PTR_TOP;
        if (MODE == MODE_RR) begin
            if (idx_reg == '0)
                ptr_next = PTR_TOP;
            else
                ptr_next = idx_reg - 1'b1;
        end
    end

    // A back-to-back grant must already see the rotated priority.
    assign search_ptr = accept ? ptr_next : ptr_reg;

    prio_find_first #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_find (
        .req   (req),
        .ptr   (search_ptr),
        .found (win_found),
        .idx   (win_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= PTR_TOP;
            idx_reg    <= '0;
            onehot_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        idx_reg    <= win_idx;
                        onehot_reg <= win_onehot;
                        state_reg  <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        ptr_reg <= ptr_next;
                        if (win_found) begin
                            idx_reg    <= win_idx;
                            onehot_reg <= win_onehot;
                        end else begin
                            onehot_reg <= '0;
                            state_reg  <= IDLE;
                        end
                    end
                end
                default: begin
                    onehot_reg <= '0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = (state_reg == HOLD);
    assign out_idx    = idx_reg;
    assign out_onehot = onehot_reg;

endmodule
